// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit that turns an ALU effective address into a valid/ack bus access,
// formatting byte/half/word lanes and reporting misaligned, illegal and timed-out accesses.
module lsu_bus_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_be,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            lane_q, lane_d;
    logic                  bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [DATA_WIDTH-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  done_q, done_d, err_q, err_d;

    logic [1:0]            lane, size;
    logic                  bad;
    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new, shifted, ld_fmt;

    assign lane = alu_result[1:0];
    assign size = funct3[1:0];
    assign bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (mem_write && funct3[2]) ||
                 (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
    assign be_new = size == 2'b00 ? 4'b0001 << lane : size == 2'b01 ? 4'b0011 << lane : 4'b1111;
    assign wdata_new = !mem_write ? '0 : size == 2'b00 ? {4{write_data[7:0]}} :
                       size == 2'b01 ? {2{write_data[15:0]}} : write_data;
    // Loads pick their byte/half from the lane latched at accept time.
    assign shifted = bus_rdata >> {lane_q, 3'b000};
    assign ld_fmt = we_q ? '0 :
                    f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]} :
                    f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} : bus_rdata;

    assign stall = req_valid & (state_q != RESP);
    assign done = done_q;
    assign err = err_q;
    assign load_data = load_data_q;
    assign bus_req = bus_req_q;
    assign bus_we = bus_we_q;
    assign bus_addr = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be = bus_be_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        we_d = we_q;
        f3_d = f3_q;
        lane_d = lane_q;
        bus_req_d = bus_req_q;
        bus_we_d = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d = bus_be_q;
        load_data_d = load_data_q;
        done_d = 1'b0;
        err_d = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                if (bad) begin
                    state_d = RESP;
                    done_d = 1'b1;
                    err_d = 1'b1;
                    load_data_d = '0;
                end else begin
                    state_d = WAIT;
                    cnt_d = '0;
                    we_d = mem_write;
                    f3_d = funct3;
                    lane_d = lane;
                    bus_req_d = 1'b1;
                    bus_we_d = mem_write;
                    bus_addr_d = {alu_result[DATA_WIDTH-1:2], 2'b00};
                    bus_wdata_d = wdata_new;
                    bus_be_d = be_new;
                end
            end
            WAIT: if (bus_ack || cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = RESP;
                done_d = 1'b1;
                err_d = !bus_ack;
                load_data_d = bus_ack ? ld_fmt : '0;
                bus_req_d = 1'b0;
                bus_we_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            we_q <= 1'b0;
            f3_q <= '0;
            lane_q <= '0;
            bus_req_q <= 1'b0;
            bus_we_q <= 1'b0;
            bus_addr_q <= '0;
            bus_wdata_q <= '0;
            bus_be_q <= '0;
            load_data_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            we_q <= we_d;
            f3_q <= f3_d;
            lane_q <= lane_d;
            bus_req_q <= bus_req_d;
            bus_we_q <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q <= bus_be_d;
            load_data_q <= load_data_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_bus_if.sv
// tb_lsu_bus_if: randomized scoreboard bench; a driver queues expected bus requests and responses,
// a monitor pops and compares them whenever the DUT raises bus_req or done.
module tb_lsu_bus_if;
    localparam int TIMEOUT = 16;

    logic        clk = 0, reset = 1, req_valid = 0, mem_write = 0, bus_ack = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] alu_result = 0, write_data = 0, bus_rdata = 0;
    logic        stall, done, err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    lsu_bus_if #(.DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_write(mem_write), .funct3(funct3),
        .alu_result(alu_result), .write_data(write_data), .stall(stall), .done(done), .err(err),
        .load_data(load_data), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;
    typedef struct { logic err; logic [31:0] ld; int cyc; } rsp_exp_t;

    bus_exp_t bq[$];
    rsp_exp_t rq[$];
    int checks = 0, errors = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    function automatic void fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endfunction

    // Reference: size in bytes, lane offset, masks and replication computed arithmetically.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd, input int w,
                                  output logic e, output logic [31:0] ld, output logic [3:0] be,
                                  output logic [31:0] wdat, output int lat);
        int n, lane;
        logic [31:0] mask, v;
        n = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        lane = int'(addr[1:0]);
        e = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5)) || (lane % n != 0);
        be = 4'(((1 << n) - 1) << lane);
        wdat = 0;
        if (we) for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wd[8*(i % n) +: 8];
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 1;
        v = (rd >> (8 * lane)) & mask;
        if (f3[2] == 0 && n < 4 && v[8*n-1]) v = v | ~mask;
        ld = we ? 32'h0 : v;
        if (e) begin
            ld = 0;
            lat = 1;
        end else if (w >= TIMEOUT) begin
            e = 1;
            ld = 0;
            lat = TIMEOUT + 1;
        end else begin
            lat = w + 2;
        end
    endfunction

    // Drive one request from the driving point (just after a rising edge); the bus acks after w idle WAIT cycles.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int w);
        bus_exp_t b;
        rsp_exp_t r;
        logic e;
        int lat, rel;
        model(we, f3, addr, wd, rd, w, e, r.ld, b.be, b.wdata, lat);
        r.err = e;
        b.we = we;
        b.addr = {addr[31:2], 2'b00};
        req_valid = 1;
        mem_write = we;
        funct3 = f3;
        alu_result = addr;
        write_data = wd;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        r.cyc = cyc + lat;
        rq.push_back(r);
        if (!(e && lat == 1)) bq.push_back(b);
        rel = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            chk("stall_busy", stall, 1);
            @(posedge clk);
            #1;
            rel++;
            bus_ack = (rel == w + 1);
            bus_rdata = (rel == w + 1) ? rd : $urandom;
            if (rel > TIMEOUT + 4) begin
                fail("no_done_within_bound");
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 0;
        bus_ack = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_bus_we"}, bus_we, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_bus_be"}, bus_be, 0);
        chk({tag, "_load_data"}, load_data, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    initial begin : monitor
        bus_exp_t cur;
        rsp_exp_t r;
        logic prev_req;
        prev_req = 0;
        cur = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 0;
            end else begin
                if (bus_req && !prev_req) begin
                    if (bq.size() == 0) fail("unexpected_bus_req");
                    else cur = bq.pop_front();
                end
                if (bus_req) begin
                    chk("bus_we", bus_we, cur.we);
                    chk("bus_addr", bus_addr, cur.addr);
                    chk("bus_be", bus_be, cur.be);
                    chk("bus_wdata", bus_wdata, cur.wdata);
                end
                prev_req = bus_req;
                if (done) begin
                    if (rq.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        r = rq.pop_front();
                        chk("err", err, r.err);
                        chk("load_data", load_data, r.ld);
                        chk("done_cycle", cyc, r.cyc);
                        chk("stall_at_done", stall, 0);
                        chk("bus_req_at_done", bus_req, 0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 0;
        @(posedge clk);
        #1;
        do_txn(0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 3);
        do_txn(0, 3'b101, 32'h12, 32'h0, 32'hBEEF_0000, 1);
        do_txn(0, 3'b001, 32'h12, 32'h0, 32'hBEEF_0000, 0);
        do_txn(1, 3'b000, 32'h401, 32'h1234_56AB, 32'hDEAD_BEEF, 2);
        do_txn(1, 3'b010, 32'h404, 32'hCAFE_F00D, 32'h0, 0);
        do_txn(0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        do_txn(1, 3'b001, 32'h3, 32'h5555, 32'h0, 0);
        do_txn(1, 3'b100, 32'h0, 32'h77, 32'h0, 0);
        do_txn(0, 3'b010, 32'h0, 32'h0, 32'h1111_2222, TIMEOUT + 1);
        do_txn(0, 3'b010, 32'h0, 32'h0, 32'h1357_9BDF, TIMEOUT - 1);
        // Reset during WAIT must drop the bus request at once and discard the access.
        req_valid = 1;
        mem_write = 0;
        funct3 = 3'b010;
        alu_result = 32'h100;
        bq.push_back('{1'b0, 32'h100, 4'hF, 32'h0});
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset = 1;
        req_valid = 0;
        #1;
        check_zero("midreset");
        rq.delete();
        bq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        bus_ack = 1;
        bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus_ack = 0;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
        end
        @(posedge clk);
        #1;
        for (int t = 0; t < 300; t++) begin
            logic [2:0] f3;
            int w;
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : $urandom_range(0, 4);
            do_txn(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom, w);
            repeat ($urandom_range(0, 2)) begin
                bus_ack = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            bus_ack = 0;
        end
        repeat (3) @(posedge clk);
        chk("rsp_queue_empty", rq.size(), 0);
        chk("bus_queue_empty", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
